// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher: host-command engine between the FT245 rx/tx FIFOs and the camera peripherals
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rx_rdata/rx_rempty/rx_rinc first-word-fall-through rx FIFO read side
//   tx_wdata/tx_wfull/tx_winc  tx FIFO write side
//   sample_req/busy/data       ADC sampler handshake and result
//   ccd_toggle/ccd_busy        CCD readout handshake
//   pwm_duty/pwm_enable        per-channel duty registers and enables
//   shutter_open               1 = open
//   err_count                  saturating error counter
module cmd_dispatcher #(
  parameter int NUM_PWM    = 4,
  parameter int PWM_W      = 8,
  parameter int RESP_BYTES = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 rx_rdata,
  input  logic                       rx_rempty,
  output logic                       rx_rinc,
  output logic [7:0]                 tx_wdata,
  input  logic                       tx_wfull,
  output logic                       tx_winc,
  output logic                       sample_req,
  input  logic                       sample_busy,
  input  logic [8*RESP_BYTES-1:0]    sample_data,
  output logic                       ccd_toggle,
  input  logic                       ccd_busy,
  output logic [NUM_PWM*PWM_W-1:0]   pwm_duty,
  output logic [NUM_PWM-1:0]         pwm_enable,
  output logic                       shutter_open,
  output logic [7:0]                 err_count
);
  localparam int PB = PWM_W / 8;
  localparam int BW = 8 * RESP_BYTES;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  typedef enum logic [3:0] {
    IDLE, DECODE, PAYLOAD, COMMIT, SAMPLE_REQ, SAMPLE_WAIT, CCD_REQ, CCD_WAIT, TX
  } state_t;
  state_t r_state, w_next;
  logic [7:0]               r_op;
  logic [1:0]               r_cnt;
  logic [TW-1:0]            r_tmo;
  logic [PWM_W-1:0]         r_stage;
  logic [BW-1:0]            r_buf;
  logic [3:0]               r_len;
  logic [NUM_PWM*PWM_W-1:0] r_duty;
  logic [NUM_PWM-1:0]       r_en;
  logic                     r_shut;
  logic [7:0]               r_err;
  logic [3:0]               w_k;
  logic [NUM_PWM-1:0]       w_mask;
  logic                     w_kok, w_err, w_pop, w_push, w_last, w_tmo;
  assign w_k   = r_op[3:0];
  assign w_kok = {28'd0, w_k} < 32'(NUM_PWM);
  // one-hot channel select; all-zero when k is out of range
  for (genvar i = 0; i < NUM_PWM; i++) begin : g_mask
    assign w_mask[i] = (w_k == 4'(i));
  end
  assign w_err = !((r_op >= 8'h01 && r_op <= 8'h04) ||
                   (r_op[7:4] >= 4'h1 && r_op[7:4] <= 4'h3 && w_kok));
  // gated by rst_n so no byte is consumed while reset is held
  assign w_pop  = rst_n && !rx_rempty && (r_state == IDLE || r_state == PAYLOAD);
  assign w_push = (r_state == TX) && !tx_wfull;
  assign w_last = (r_cnt == 2'(PB - 1));
  assign w_tmo  = rx_rempty && (r_tmo == TW'(TIMEOUT - 1));
  assign rx_rinc      = w_pop;
  assign tx_winc      = w_push;
  assign tx_wdata     = (r_state == TX) ? r_buf[7:0] : 8'h00;
  assign sample_req   = (r_state == SAMPLE_REQ);
  assign ccd_toggle   = (r_state == CCD_REQ);
  assign pwm_duty     = r_duty;
  assign pwm_enable   = r_en;
  assign shutter_open = r_shut;
  assign err_count    = r_err;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:        w_next = w_pop ? DECODE : IDLE;
      DECODE:      w_next = w_err ? TX : (r_op == 8'h01) ? SAMPLE_REQ : (r_op == 8'h02) ? CCD_REQ :
                            (r_op[7:4] == 4'h1) ? PAYLOAD : IDLE;
      PAYLOAD:     w_next = (w_pop && w_last) ? COMMIT : (!w_pop && w_tmo) ? TX : PAYLOAD;
      COMMIT:      w_next = IDLE;
      SAMPLE_REQ:  w_next = sample_busy ? SAMPLE_WAIT : SAMPLE_REQ;
      SAMPLE_WAIT: w_next = sample_busy ? SAMPLE_WAIT : TX;
      CCD_REQ:     w_next = ccd_busy ? CCD_WAIT : CCD_REQ;
      CCD_WAIT:    w_next = ccd_busy ? CCD_WAIT : TX;
      TX:          w_next = (w_push && r_len == 4'd1) ? IDLE : TX;
      default:     w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= '0;
      r_cnt   <= '0;
      r_tmo   <= '0;
      r_stage <= '0;
      r_buf   <= '0;
      r_len   <= '0;
      r_duty  <= '0;
      r_en    <= '0;
      r_shut  <= 1'b0;
      r_err   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_pop) r_op <= rx_rdata;
        DECODE: begin
          r_cnt  <= '0;
          r_tmo  <= '0;
          r_shut <= (r_op == 8'h03) ? 1'b1 : (r_op == 8'h04) ? 1'b0 : r_shut;
          r_en   <= (r_op[7:4] == 4'h2) ? (r_en | w_mask) :
                    (r_op[7:4] == 4'h3) ? (r_en & ~w_mask) : r_en;
          if (w_err) begin
            r_err <= r_err + 8'(r_err != 8'hFF);
            r_buf <= BW'(8'hEE);
            r_len <= 4'd1;
          end
        end
        PAYLOAD:
          if (w_pop) begin
            r_stage <= (r_stage << 8) | PWM_W'(rx_rdata);
            r_cnt   <= r_cnt + 2'd1;
            r_tmo   <= '0;
          end else if (w_tmo) begin
            r_stage <= '0;
            r_err   <= r_err + 8'(r_err != 8'hFF);
            r_buf   <= BW'(8'hEE);
            r_len   <= 4'd1;
          end else r_tmo <= r_tmo + 1'b1;
        COMMIT:
          for (int i = 0; i < NUM_PWM; i++)
            if (w_mask[i]) r_duty[i*PWM_W +: PWM_W] <= r_stage;
        SAMPLE_WAIT:
          if (!sample_busy) begin
            r_buf <= sample_data;
            r_len <= 4'(RESP_BYTES);
          end
        CCD_WAIT:
          if (!ccd_busy) begin
            r_buf <= BW'(8'hA5);
            r_len <= 4'd1;
          end
        // buffer drains LSB byte first by shifting down
        TX:
          if (w_push) begin
            r_buf <= r_buf >> 8;
            r_len <= r_len - 4'd1;
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cmd_dispatcher.sv
// tb_cmd_dispatcher: scoreboard bench for cmd_dispatcher (NUM_PWM=4, PWM_W=16, RESP_BYTES=4, TIMEOUT=16)
module tb_cmd_dispatcher;
  localparam int NP = 4, PW = 16, RB = 4, TO = 16;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  logic [7:0]     rx_rdata, tx_wdata, err_count, e;
  logic           rx_rempty, rx_rinc, tx_wfull, tx_winc;
  logic           sample_req, ccd_toggle, shutter_open;
  logic           sample_busy = 1'b0, ccd_busy = 1'b0;
  logic [8*RB-1:0] sample_data;
  logic [NP*PW-1:0] pwm_duty;
  logic [NP-1:0]  pwm_enable;
  logic [7:0]     rx_mem [1024];
  int             rx_wp = 0, rx_rp = 0;
  logic [7:0]     exp_q [$];
  int             vectors = 0, miscompares = 0;
  int             s_cnt = 0, c_cnt = 0;
  bit             hold = 1'b0;
  logic [7:0]     bad [10] = '{8'h00, 8'h05, 8'h0F, 8'h14, 8'h1F, 8'h24, 8'h3C, 8'h40, 8'h99, 8'hFF};
  cmd_dispatcher #(.NUM_PWM(NP), .PWM_W(PW), .RESP_BYTES(RB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_rdata(rx_rdata), .rx_rempty(rx_rempty), .rx_rinc(rx_rinc),
    .tx_wdata(tx_wdata), .tx_wfull(tx_wfull), .tx_winc(tx_winc),
    .sample_req(sample_req), .sample_busy(sample_busy), .sample_data(sample_data),
    .ccd_toggle(ccd_toggle), .ccd_busy(ccd_busy),
    .pwm_duty(pwm_duty), .pwm_enable(pwm_enable),
    .shutter_open(shutter_open), .err_count(err_count)
  );
  assign rx_rempty = (rx_wp == rx_rp);
  assign rx_rdata  = rx_mem[rx_rp[9:0]];
  always @(posedge clk) if (rx_rinc) rx_rp <= rx_rp + 1;
  always @(posedge clk) begin
    if (s_cnt > 0) begin
      s_cnt <= s_cnt - 1;
      if (s_cnt == 1) sample_busy <= 1'b0;
    end else if (sample_req && !sample_busy && !hold) begin
      sample_busy <= 1'b1;
      s_cnt <= 20;
    end
  end
  always @(posedge clk) begin
    if (c_cnt > 0) begin
      c_cnt <= c_cnt - 1;
      if (c_cnt == 1) ccd_busy <= 1'b0;
    end else if (ccd_toggle && !ccd_busy) begin
      ccd_busy <= 1'b1;
      c_cnt <= 100;
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rx_rinc && rx_rempty) begin
      miscompares++;
      $display("FAIL rx_pop_empty: rx_rinc=1 expected 0 while empty");
    end
    if (tx_winc) begin
      if (tx_wfull) begin
        miscompares++;
        $display("FAIL tx_push_full: tx_winc=1 expected 0 while full");
      end
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL tx_unexpected: got byte %0h expected none", tx_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("tx_byte", 64'(tx_wdata), 64'(e));
        if (tx_wdata == 8'hA5) chk("shutter_at_ack", 64'(shutter_open), 64'd0);
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(input logic [7:0] b);
    rx_mem[rx_wp[9:0]] = b;
    rx_wp++;
  endtask
  task automatic drain(input string nm, input int lim);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rx_wp != rx_rp) && n < lim) begin
      cyc(1);
      n++;
    end
    if (n >= lim) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: %0d bytes pending, expected 0", nm, exp_q.size());
    end
    cyc(4);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, rp0;
    rst_n = 1'b0;
    tx_wfull = 1'b0;
    sample_data = 32'h04030201;
    cyc(3);
    chk("rst_duty", pwm_duty, 64'd0);
    chk("rst_en", 64'(pwm_enable), 64'd0);
    chk("rst_shutter", 64'(shutter_open), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    chk("rst_strobes", {60'd0, rx_rinc, tx_winc, sample_req, ccd_toggle}, 64'd0);
    chk("rst_txdata", 64'(tx_wdata), 64'd0);
    rst_n = 1'b1;
    cyc(2);
    rp0 = rx_rp;
    push(8'h12); push(8'hAB); push(8'hCD);
    n = 0;
    while (rx_rp != rp0 + 3 && n < 50) begin cyc(1); n++; end
    chk("duty2_before_commit", pwm_duty, 64'd0);
    cyc(1);
    chk("duty2_commit", pwm_duty, 64'h0000_ABCD_0000_0000);
    push(8'h11); push(8'h12); push(8'h34);
    drain("duty1", 100);
    chk("duty1", pwm_duty, 64'h0000_ABCD_1234_0000);
    push(8'h11); push(8'h56);
    exp_q.push_back(8'hEE);
    drain("payload_timeout", 200);
    chk("timeout_duty", pwm_duty, 64'h0000_ABCD_1234_0000);
    chk("timeout_err", 64'(err_count), 64'd1);
    push(8'h11);
    cyc(TO - 3);
    push(8'h77);
    cyc(TO - 3);
    push(8'h88);
    drain("slow_payload", 200);
    chk("slow_payload_duty", pwm_duty, 64'h0000_ABCD_7788_0000);
    chk("slow_payload_err", 64'(err_count), 64'd1);
    push(8'h21);
    drain("enable1", 50);
    chk("enable1", 64'(pwm_enable), 64'h2);
    push(8'h01);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03); exp_q.push_back(8'h04);
    n = 0;
    while (!tx_winc && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("sample_first_byte_wait", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    tx_wfull = 1'b1;
    sample_data = 32'hDEADBEEF;
    cyc(5);
    tx_wfull = 1'b0;
    drain("sample", 300);
    rp0 = rx_rp;
    push(8'h02); push(8'h03);
    exp_q.push_back(8'hA5);
    cyc(50);
    chk("ccd_holds_next_op", 64'(rx_rp - rp0), 64'd1);
    chk("ccd_shutter_busy", 64'(shutter_open), 64'd0);
    chk("ccd_toggle_wait", 64'(ccd_toggle), 64'd0);
    drain("ccd", 300);
    chk("shutter_open", 64'(shutter_open), 64'd1);
    push(8'h7F); push(8'h25);
    exp_q.push_back(8'hEE); exp_q.push_back(8'hEE);
    drain("bad_ops", 100);
    chk("err_after_two", 64'(err_count), 64'd3);
    for (int i = 0; i < 300; i++) begin
      push(bad[i % 10]);
      exp_q.push_back(8'hEE);
    end
    drain("bad_flood", 2000);
    chk("err_saturated", 64'(err_count), 64'hFF);
    chk("bad_en_unchanged", 64'(pwm_enable), 64'h2);
    chk("bad_duty_unchanged", pwm_duty, 64'h0000_ABCD_7788_0000);
    hold = 1'b1;
    push(8'h01);
    n = 0;
    while (!sample_req && n < 20) begin cyc(1); n++; end
    chk("sample_req_up", 64'(sample_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sreq_sample_req", 64'(sample_req), 64'd0);
    chk("rst_sreq_outputs", {pwm_duty}, 64'd0);
    chk("rst_sreq_misc", {51'd0, pwm_enable, shutter_open, err_count}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold = 1'b0;
    cyc(2);
    push(8'h23);
    drain("enable3", 50);
    chk("enable3", 64'(pwm_enable), 64'h8);
    push(8'h11); push(8'h99);
    cyc(5);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_payload_en", 64'(pwm_enable), 64'd0);
    chk("rst_payload_strobes", {60'd0, rx_rinc, tx_winc, sample_req, ccd_toggle}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(2);
    push(8'h20);
    drain("enable0", 50);
    chk("enable0_after_reset", 64'(pwm_enable), 64'h1);
    chk("duty_after_reset", pwm_duty, 64'd0);
    chk("err_after_reset", 64'(err_count), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cmd_dispatcher.md
Name: cmd_dispatcher

Overview:
- Parametrised host-command engine between the FT245 rx/tx FIFOs and the camera peripherals: ADC sampler, CCD readout sequencer, shutter, and N PWM outputs.
- Pops opcode and payload bytes, applies settings atomically, triggers and waits on peripheral handshakes, and streams multi-byte responses.
- Adds three behaviours the current controller lacks: explicit error replies, payload timeouts, and a completion acknowledge.

Parameters:
NUM_PWM, 4, number of PWM duty/enable channels (1..16)
PWM_W, 8, duty register width; must be 8 or 16; payload bytes PB = PWM_W/8
RESP_BYTES, 4, bytes per sample response (1..8)
TIMEOUT, 1024, idle cycles allowed while waiting for a payload byte (≥2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_rdata  in  8  rx FIFO head byte (first-word-fall-through, valid while rx_rempty=0)
rx_rempty  in  1  rx FIFO empty
rx_rinc  out  1  pop rx FIFO head this cycle
tx_wdata  out  8  byte to tx FIFO
tx_wfull  in  1  tx FIFO full
tx_winc  out  1  push tx_wdata this cycle
sample_req  out  1  ADC sample request
sample_busy  in  1  ADC interface busy
sample_data  in  8*RESP_BYTES  ADC result, stable once busy falls
ccd_toggle  out  1  CCD readout request
ccd_busy  in  1  CCD readout busy
pwm_duty  out  NUM_PWM*PWM_W  duty registers, channel k at [k*PWM_W +: PWM_W]
pwm_enable  out  NUM_PWM  per-channel enable
shutter_open  out  1  1 = open, 0 = closed
err_count  out  8  saturating error counter

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs are 0: pwm_duty, pwm_enable, shutter_open (closed), err_count, tx_wdata, and all strobes. Strobes drop immediately, including mid-operation. Partial payloads are discarded.
- FIFO rules:
  - rx_rinc is asserted only when rx_rempty=0; the byte is consumed in the same cycle.
  - tx_winc is asserted only when tx_wfull=0, with tx_wdata valid in that cycle.
  - While the tx FIFO is full, TX holds its byte; no byte is dropped or duplicated.
- Opcodes (k = opcode[3:0]):
  - 0x01: sample.
  - 0x02: CCD readout.
  - 0x03: shutter open.
  - 0x04: shutter close.
  - 0x1k: set duty k, followed by PB bytes, MSB first.
  - 0x2k: enable channel k.
  - 0x3k: disable channel k.
  - Any other opcode, or any k ≥ NUM_PWM, is an error.
- States: IDLE, DECODE, PAYLOAD, COMMIT, SAMPLE_REQ, SAMPLE_WAIT, CCD_REQ, CCD_WAIT, TX.
- IDLE: if rx_rempty=0, pop the opcode into an internal register and go to DECODE next cycle.
- DECODE (1 cycle):
  - Shutter and enable/disable commands update their outputs on the DECODE clock edge (visible 2 cycles after the pop), then go to IDLE.
  - 0x1k goes to PAYLOAD with byte count 0.
  - 0x01 goes to SAMPLE_REQ; 0x02 goes to CCD_REQ.
  - Error: err_count++ (saturates at 0xFF), load 0xEE, go to TX with length 1.
- PAYLOAD:
  - When not empty, pop a byte, shift it into the staging register and reset the timeout counter.
  - After PB bytes, go to COMMIT.
  - Each empty cycle increments the timeout counter. On reaching TIMEOUT: discard staging, err_count++, send 0xEE, leave pwm_duty unchanged.
- COMMIT (1 cycle): write staging into channel k only; other channels are untouched. Go to IDLE.
- SAMPLE_REQ:
  - Hold sample_req=1 until sample_busy=1, then go to SAMPLE_WAIT.
  - SAMPLE_WAIT: when sample_busy=0, latch sample_data and go to TX with length RESP_BYTES, LSB byte first.
- CCD_REQ:
  - Hold ccd_toggle=1 until ccd_busy=1.
  - CCD_WAIT: when ccd_busy=0, go to TX with the single byte 0xA5 (completion ack).
- TX: emit bytes from the latched buffer, one per non-full cycle. After the last byte, go to IDLE.
- Ordering: commands are processed strictly in order. Opcodes arriving while busy remain in the rx FIFO; no pipelining across commands.
- Response data is latched, so sample_data changing during TX has no effect.

Test Plan:
- Reset, then push 0x12,0xAB (NUM_PWM=4, PWM_W=8) -> channel 2 duty becomes 0xAB one cycle after the second pop; other duties stay 0; no tx bytes.
- PWM_W=16: push 0x11,0x12,0x34 -> duty1=0x1234. Push 0x11,0x56, then starve for TIMEOUT cycles -> duty1 stays 0x1234, tx emits 0xEE, err_count=1.
- Push 0x01; model asserts busy for 20 cycles with sample_data=0x04030201; hold tx_wfull=1 for 5 cycles mid-stream -> tx sequence exactly 0x01,0x02,0x03,0x04, no duplicates.
- Push 0x02 then 0x03 back-to-back; ccd_busy high for 100 cycles -> 0xA5 sent after busy falls; shutter_open rises only after the 0xA5 push.
- Push 0x7F, 0x25 (NUM_PWM=4), and 300 further invalid bytes -> each yields 0xEE; err_count saturates at 0xFF; pwm_enable unchanged.
- Deassert rst_n while in SAMPLE_REQ and while in PAYLOAD -> sample_req and all outputs go to 0 immediately; after release, a 0x20 command enables channel 0 normally.
